// File: rtl/nes_joypad_mux_pkg.sv
// nes_joypad_pkg: shared constants and helpers for the NES joypad front-end.
//   - BTN_*  : bit positions inside a pad byte, NES shift order (A first).
//   - RAW_*  : bit positions of the six raw DB9 pins inside one port slice.
//   - SIG_*  : Four Score signature bytes for $4016 / $4017.
//   - make_pad_byte : builds a pad byte from active-high pins plus OSD buttons.
// Optional feature macro used by the design: JOYPAD_TURBO_EN.
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int RAW_A      = 0;
  localparam int RAW_B      = 1;
  localparam int RAW_UP     = 2;
  localparam int RAW_DOWN   = 3;
  localparam int RAW_LEFT   = 4;
  localparam int RAW_RIGHT  = 5;
  localparam int RAW_WIDTH  = 6;

  localparam int SHIFT_WIDTH = 24;

  localparam logic [7:0] SIG_4016 = 8'h08;
  localparam logic [7:0] SIG_4017 = 8'h04;

  // fire_gate lets turbo blank A/B without touching the directions.
  function automatic logic [7:0] make_pad_byte(input logic [RAW_WIDTH-1:0] btn,
                                               input logic start,
                                               input logic select,
                                               input logic fire_gate);
    logic [7:0] pad;
    pad             = '0;
    pad[BTN_A]      = btn[RAW_A] & fire_gate;
    pad[BTN_B]      = btn[RAW_B] & fire_gate;
    pad[BTN_SELECT] = select;
    pad[BTN_START]  = start;
    pad[BTN_UP]     = btn[RAW_UP];
    pad[BTN_DOWN]   = btn[RAW_DOWN];
    pad[BTN_LEFT]   = btn[RAW_LEFT];
    pad[BTN_RIGHT]  = btn[RAW_RIGHT];
    return pad;
  endfunction

endpackage

// File: rtl/nes_joypad_mux_if.sv
// nes_joypad_mux_if: serial controller bus between the NES core and the
// joypad front-end.
//   joy_strobe : core strobe ($4016 bit 0)
//   joy_clock  : read pulses, bit 0 = $4016, bit 1 = $4017
//   joy_data   : serial data back to the core, same bit mapping
// Modports: master = NES core side, slave = joypad front-end side.
interface nes_joypad_mux_if;
  logic       joy_strobe;
  logic [1:0] joy_clock;
  logic [1:0] joy_data;

  modport master (output joy_strobe, output joy_clock, input joy_data);
  modport slave  (input joy_strobe, input joy_clock, output joy_data);
endinterface

// File: rtl/nes_joypad_mux_shifter.sv
// nes_joypad_shifter: one 24-bit controller shift register.
//   clk, reset_n : system clock, async active-low reset
//   strobe       : parallel load every cycle while high
//   joy_clock    : read pulse; a falling edge shifts one bit out
//   load_value   : {signature, padB, padA}, LSB read first
//   data         : registered serial output (1 in reset)
module nes_joypad_shifter
  import nes_joypad_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   strobe,
  input  logic                   joy_clock,
  input  logic [SHIFT_WIDTH-1:0] load_value,
  output logic                   data
);

  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [SHIFT_WIDTH-1:0] shift_d;
  logic                   last_clock;

  // Load has priority over a coincident falling edge; ones fill from the top
  // so an over-read returns 1 forever.
  always_comb begin
    shift_d = shift_q;
    if (strobe) begin
      shift_d = load_value;
    end else if (last_clock && !joy_clock) begin
      shift_d = {1'b1, shift_q[SHIFT_WIDTH-1:1]};
    end
  end

  // data follows the next shifter value so the core sees the new bit one
  // cycle after a strobe or falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      last_clock <= 1'b0;
      data       <= 1'b1;
    end else begin
      shift_q    <= shift_d;
      last_clock <= joy_clock;
      data       <= shift_d[0];
    end
  end

endmodule

// File: rtl/nes_joypad_mux.sv
// nes_joypad_mux: DB9 joystick ports to NES $4016/$4017 serial interface.
//   clk, reset_n : system clock, async active-low reset
//   port_raw     : NUM_PORTS x 6 raw active-low pins {A,B,U,D,L,R} LSB first
//   split_sel    : joySplitter select line (0 = slot 0, 1 = slot 1)
//   host_start, host_select : OSD buttons, OR'd into every present pad
//   turbo_en     : per-pad turbo enable (only with JOYPAD_TURBO_EN)
//   joy          : core-side serial bus (strobe, clock, data)
// Optional feature: define JOYPAD_TURBO_EN to add turbo on A/B.
module nes_joypad_mux
  import nes_joypad_pkg::*;
#(
  parameter int  NUM_PORTS = 1,
  parameter int  SPLIT     = 1,
  parameter int  SPLIT_DIV = 512,
  parameter int  TURBO_DIV = 350000,
  localparam int NUM_PADS  = (NUM_PORTS * (SPLIT + 1) > 4) ? 4 : NUM_PORTS * (SPLIT + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PORTS*RAW_WIDTH-1:0] port_raw,
  output logic                           split_sel,
  input  logic                           host_start,
  input  logic                           host_select,
`ifdef JOYPAD_TURBO_EN
  input  logic [NUM_PADS-1:0]            turbo_en,
`endif
  nes_joypad_mux_if.slave                joy
);

  localparam int SPLIT_W = (SPLIT_DIV > 1) ? $clog2(SPLIT_DIV) : 1;

  logic [NUM_PORTS*RAW_WIDTH-1:0] raw_meta;
  logic [NUM_PORTS*RAW_WIDTH-1:0] raw_sync;
  logic [NUM_PORTS*RAW_WIDTH-1:0] btn_now;
  logic [1:0]                     host_meta;
  logic [1:0]                     host_sync;
  logic [SPLIT_W-1:0]             phase_cnt;
  logic [RAW_WIDTH-1:0]           slot_q [4];
  logic [7:0]                     pad_byte [4];
  logic [SHIFT_WIDTH-1:0]         load_4016;
  logic [SHIFT_WIDTH-1:0]         load_4017;
  logic [3:0]                     turbo_mask;
  logic                           turbo_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_meta  <= '0;
      raw_sync  <= '0;
      host_meta <= '0;
      host_sync <= '0;
    end else begin
      raw_meta  <= port_raw;
      raw_sync  <= raw_meta;
      host_meta <= {host_select, host_start};
      host_sync <= host_meta;
    end
  end

  assign btn_now = ~raw_sync;

`ifdef JOYPAD_TURBO_EN
  localparam int TURBO_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [NUM_PADS-1:0] turbo_meta;
  logic [NUM_PADS-1:0] turbo_sync;
  logic [TURBO_W-1:0]  turbo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      turbo_meta  <= '0;
      turbo_sync  <= '0;
      turbo_cnt   <= '0;
      turbo_phase <= 1'b1;
    end else begin
      turbo_meta <= turbo_en;
      turbo_sync <= turbo_meta;
      if (turbo_cnt == TURBO_W'(TURBO_DIV - 1)) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 1'b1;
      end
    end
  end

  assign turbo_mask = 4'(turbo_sync);
`else
  assign turbo_mask  = 4'b0000;
  assign turbo_phase = 1'b1;
`endif

  // A slot is only written at the end of its select phase, so the sample
  // always belongs to a single, fully settled joySplitter phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
      split_sel <= 1'b0;
      for (int s = 0; s < 4; s++) begin
        slot_q[s] <= '0;
      end
    end else if (SPLIT == 0) begin
      split_sel <= 1'b0;
      phase_cnt <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        slot_q[2'(p)] <= btn_now[p*RAW_WIDTH +: RAW_WIDTH];
      end
    end else if (phase_cnt == SPLIT_W'(SPLIT_DIV - 1)) begin
      phase_cnt <= '0;
      split_sel <= ~split_sel;
      for (int p = 0; p < NUM_PORTS; p++) begin
        slot_q[2'(2 * p + int'(split_sel))] <= btn_now[p*RAW_WIDTH +: RAW_WIDTH];
      end
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Pads beyond NUM_PADS stay zero, including the OSD bits.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      pad_byte[q] = '0;
      if (q < NUM_PADS) begin
        pad_byte[q] = make_pad_byte(slot_q[q], host_sync[0], host_sync[1],
                                    ~turbo_mask[q] | turbo_phase);
      end
    end
  end

  // Without a Four Score there is no signature, reads past pad A return 1.
  always_comb begin
    load_4016 = {SIG_4016, pad_byte[2], pad_byte[0]};
    load_4017 = {SIG_4017, pad_byte[3], pad_byte[1]};
    if (NUM_PADS <= 2) begin
      load_4016[SHIFT_WIDTH-1:8] = '1;
      load_4017[SHIFT_WIDTH-1:8] = '1;
    end
  end

  nes_joypad_shifter u_shift_4016 (
    .clk        (clk),
    .reset_n    (reset_n),
    .strobe     (joy.joy_strobe),
    .joy_clock  (joy.joy_clock[0]),
    .load_value (load_4016),
    .data       (joy.joy_data[0])
  );

  nes_joypad_shifter u_shift_4017 (
    .clk        (clk),
    .reset_n    (reset_n),
    .strobe     (joy.joy_strobe),
    .joy_clock  (joy.joy_clock[1]),
    .load_value (load_4017),
    .data       (joy.joy_data[1])
  );

endmodule

// File: tb/tb_nes_joypad_mux.sv
// tb_nes_joypad_mux: scoreboard bench for nes_joypad_mux.
//   dut_a : NUM_PORTS=2, SPLIT=1, SPLIT_DIV=4 (Four Score, 4 pads)
//   dut_b : NUM_PORTS=1, SPLIT=0 (single pad)
// Both DUTs share strobe/clock timing; each expected observation is queued
// when stimulus is issued and the monitor compares on the following negedge.
// Turbo checks are compiled in only with JOYPAD_TURBO_EN.
module tb_nes_joypad_mux;

  typedef struct {
    string      tag;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic       chk_sel;
    logic       force_fail;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] port_raw_a;
  logic [11:0] raw_sel0;
  logic [11:0] raw_sel1;
  logic [5:0]  port_raw_b;
  logic        split_sel_a;
  logic        split_sel_b;
  logic        host_start;
  logic        host_select;
`ifdef JOYPAD_TURBO_EN
  logic [3:0]  turbo_en_a;
  logic [0:0]  turbo_en_b;
`endif

  logic        obs_valid = 1'b0;
  obs_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [23:0] str_a0, str_a1, str_b0, str_b1;
  int          idx;

  always #5 clk = ~clk;

  // Port 0/1 pins of dut_a follow the joySplitter select, like real pads.
  assign port_raw_a = split_sel_a ? raw_sel1 : raw_sel0;

  nes_joypad_mux_if bus_a ();
  nes_joypad_mux_if bus_b ();

  nes_joypad_mux #(.NUM_PORTS(2), .SPLIT(1), .SPLIT_DIV(4), .TURBO_DIV(4)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .port_raw    (port_raw_a),
    .split_sel   (split_sel_a),
    .host_start  (host_start),
    .host_select (host_select),
`ifdef JOYPAD_TURBO_EN
    .turbo_en    (turbo_en_a),
`endif
    .joy         (bus_a.slave)
  );

  nes_joypad_mux #(.NUM_PORTS(1), .SPLIT(0), .SPLIT_DIV(4), .TURBO_DIV(4)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .port_raw    (port_raw_b),
    .split_sel   (split_sel_b),
    .host_start  (host_start),
    .host_select (host_select),
`ifdef JOYPAD_TURBO_EN
    .turbo_en    (turbo_en_b),
`endif
    .joy         (bus_b.slave)
  );

  function automatic logic sbit(input logic [23:0] s, input int i);
    if (i > 23) return 1'b1;
    return s[i];
  endfunction

  task automatic check_output(input obs_t it);
    n_checks++;
    if (it.force_fail) begin
      n_fail++;
      $display("[TB] FAIL %s: wait bound expired, split_sel_a=%b required 1", it.tag, split_sel_a);
      return;
    end
    if (bus_a.joy_data !== it.exp_a) begin
      n_fail++;
      $display("[TB] FAIL %s dut_a joy_data: got %b required %b", it.tag, bus_a.joy_data, it.exp_a);
    end
    n_checks++;
    if (bus_b.joy_data !== it.exp_b) begin
      n_fail++;
      $display("[TB] FAIL %s dut_b joy_data: got %b required %b", it.tag, bus_b.joy_data, it.exp_b);
    end
    if (it.chk_sel) begin
      n_checks++;
      if ({split_sel_a, split_sel_b} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL %s split_sel: got a=%b b=%b required 0 0", it.tag, split_sel_a, split_sel_b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard: observation with empty queue, got %b/%b required queued item",
                 bus_a.joy_data, bus_b.joy_data);
      end else begin
        check_output(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_raw(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                          input logic chk_sel, input logic force_fail);
    obs_t it;
    it.tag        = tag;
    it.exp_a      = ea;
    it.exp_b      = eb;
    it.chk_sel    = chk_sel;
    it.force_fail = force_fail;
    sb_q.push_back(it);
    obs_valid = 1'b1;
  endtask

  task automatic push_stream(input string tag);
    push_raw($sformatf("%s[%0d]", tag, idx),
             {sbit(str_a1, idx), sbit(str_a0, idx)},
             {sbit(str_b1, idx), sbit(str_b0, idx)}, 1'b0, 1'b0);
  endtask

  task automatic set_strobe(input logic v);
    bus_a.joy_strobe = v;
    bus_b.joy_strobe = v;
  endtask

  task automatic set_clock(input logic [1:0] v);
    bus_a.joy_clock = v;
    bus_b.joy_clock = v;
  endtask

  task automatic strobe_load(input string tag);
    set_strobe(1'b1);
    tick();
    set_strobe(1'b0);
    idx = 0;
    push_stream(tag);
  endtask

  // One read pulse on both channels; a held strobe reloads instead of shifting.
  task automatic apply_stimulus(input string tag);
    set_clock(2'b11);
    tick();
    set_clock(2'b00);
    tick();
    idx = bus_a.joy_strobe ? 0 : idx + 1;
    push_stream(tag);
  endtask

  task automatic read_sequence(input string tag, input int reads);
    strobe_load(tag);
    for (int k = 0; k < reads; k++) apply_stimulus(tag);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    set_strobe(1'b0);
    set_clock(2'b00);
    host_start  = 1'b0;
    host_select = 1'b0;
    raw_sel0    = 12'hFFF;
    raw_sel1    = 12'hFFF;
    port_raw_b  = 6'h3F;
`ifdef JOYPAD_TURBO_EN
    turbo_en_a  = 4'b0000;
    turbo_en_b  = 1'b0;
`endif
    idx = 0;

    tick();
    push_raw("reset", 2'b11, 2'b11, 1'b1, 1'b0);
    wait_cycles(2);
    reset_n = 1'b1;

    $display("[TB] four score idle / single pad A pressed");
    port_raw_b = 6'b111110;
    wait_cycles(20);
    str_a0 = {8'h08, 8'h00, 8'h00};
    str_a1 = {8'h04, 8'h00, 8'h00};
    str_b0 = {16'hFFFF, 8'h01};
    str_b1 = {16'hFFFF, 8'h00};
    read_sequence("fourscore", 26);

    $display("[TB] joySplitter slot mapping");
    port_raw_b = 6'h3F;
    raw_sel0 = {6'b011111, 6'b111111};
    raw_sel1 = {6'b111111, 6'b111011};
    wait_cycles(20);
    str_a0 = {8'h08, 8'h80, 8'h00};
    str_a1 = {8'h04, 8'h00, 8'h10};
    str_b0 = {16'hFFFF, 8'h00};
    str_b1 = {16'hFFFF, 8'h00};
    read_sequence("splitter", 25);

    $display("[TB] OSD start / select merge");
    raw_sel0 = 12'hFFF;
    raw_sel1 = 12'hFFF;
    host_start = 1'b1;
    wait_cycles(20);
    str_a0 = {8'h08, 8'h08, 8'h08};
    str_a1 = {8'h04, 8'h08, 8'h08};
    str_b0 = {16'hFFFF, 8'h08};
    str_b1 = {16'hFFFF, 8'h00};
    read_sequence("osd_start", 10);
    host_start  = 1'b0;
    host_select = 1'b1;
    wait_cycles(8);
    str_a0 = {8'h08, 8'h04, 8'h04};
    str_a1 = {8'h04, 8'h04, 8'h04};
    str_b0 = {16'hFFFF, 8'h04};
    read_sequence("osd_select", 10);

    $display("[TB] strobe held during read pulses");
    host_select = 1'b0;
    raw_sel0 = {6'h3F, 6'b111101};
    raw_sel1 = {6'h3F, 6'b111101};
    wait_cycles(20);
    str_a0 = {8'h08, 8'h00, 8'h02};
    str_a1 = {8'h04, 8'h00, 8'h02};
    str_b0 = {16'hFFFF, 8'h00};
    str_b1 = {16'hFFFF, 8'h00};
    set_strobe(1'b1);
    tick();
    idx = 0;
    push_stream("strobe_held");
    for (int k = 0; k < 3; k++) apply_stimulus("strobe_held");
    set_strobe(1'b0);
    for (int k = 0; k < 4; k++) apply_stimulus("after_strobe");

    $display("[TB] async reset mid-read");
    read_sequence("pre_reset", 3);
    n = 0;
    do begin
      tick();
      n++;
    end while (!split_sel_a && n < 16);
    if (!split_sel_a) begin
      push_raw("wait_split_sel", 2'b11, 2'b11, 1'b0, 1'b1);
      tick();
    end
    reset_n = 1'b0;
    push_raw("reset_mid", 2'b11, 2'b11, 1'b1, 1'b0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(20);
    read_sequence("post_reset", 8);

`ifdef JOYPAD_TURBO_EN
    $display("[TB] turbo on pad 0 A");
    tick();
    reset_n    = 1'b0;
    raw_sel0   = {6'h3F, 6'b111110};
    raw_sel1   = {6'h3F, 6'b111110};
    port_raw_b = 6'b111110;
    turbo_en_a = 4'b0001;
    turbo_en_b = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(19);
    str_a1 = {8'h04, 8'h00, 8'h01};
    str_b1 = {16'hFFFF, 8'h00};
    for (int k = 0; k < 4; k++) begin
      logic ph;
      ph = (k % 2 == 0) ? 1'b1 : 1'b0;
      str_a0 = {8'h08, 8'h00, 7'b0, ph};
      str_b0 = {16'hFFFF, 7'b0, ph};
      strobe_load("turbo");
      if (k < 3) wait_cycles(3);
    end
`endif

    wait_cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_joypad_mux.md
# nes_joypad_mux

Parametrised NES controller front-end between the board's DB9 joystick ports and the NES core's `$4016/$4017` serial interface. It scans one or two physical ports, each optionally time-multiplexed through a joySplitter. It maps them to 1–4 logical pads, merges the OSD Start/Select buttons, and serialises the pads to the core. It adds Four Score protocol for more than two pads and optional turbo.

## Interface
Parameters:
- `NUM_PORTS`, 1: physical DB9 ports, 1 or 2.
- `SPLIT`, 1: 1 = each port carries two pads via joySplitter; 0 = one pad per port.
- `SPLIT_DIV`, 512: `clk` cycles per joySplitter select phase, ≥4.
- `TURBO_DIV`, 350000: `clk` cycles per turbo half-period.
- Derived `NUM_PADS` = min(4, NUM_PORTS×(SPLIT+1)).

Ports:
- `clk`  in  1  system clock, ~21.48 MHz NES clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `port_raw`  in  NUM_PORTS×6  raw port pins, active-low; per port, LSB first: {A(F1), B(F2), U, D, L, R}.
- `split_sel`  out  1  joySplitter select line (Fire3 pin); 0 = pad slot 0, 1 = pad slot 1.
- `host_start`, `host_select`  in  1 each  OSD buttons, active-high; OR'd into every pad.
- `joy_strobe`  in  1  core strobe (`$4016` bit 0).
- `joy_clock`  in  2  core read pulses for `$4016` and `$4017`.
- `joy_data`  out  2  serial data to the core, bit 0 = `$4016`, bit 1 = `$4017`.
- `turbo_en`  in  NUM_PADS  per-pad turbo enable; present only with `JOYPAD_TURBO_EN`.

## Operation
- Synchroniser: `port_raw`, `host_*` and `turbo_en` each pass through a two-flop synchroniser, then are inverted to active-high.
- Scanner: the phase counter counts 0..SPLIT_DIV−1. On count SPLIT_DIV−1, synced port data is latched into pad slot [port×2+split_sel], then `split_sel` toggles and the counter wraps. When SPLIT=0, `split_sel` is held at 0 and each pad is latched every cycle.
- Pad byte, LSB first in NES order: {A, B, Select, Start, U, D, L, R}. Select and Start come from the OSD.
- Pad mapping: `$4016` carries pads 0 and 2; `$4017` carries pads 1 and 3.
- Shifter per channel, as a 24-bit register:
  - Loaded every cycle while `joy_strobe`=1, with {signature, padB, padA}, where padA = pad 0 or 1 and padB = pad 2 or 3.
  - Signature is 8'h08 on `$4016` and 8'h04 on `$4017`, LSB first, so the Four Score ID bit is read as bit 19 or bit 18.
  - If NUM_PADS ≤ 2, the whole {signature, padB} field loads as all-ones.
  - Missing pads load 0.
- Shift: on a falling edge of `joy_clock[i]` (prev=1, now=0) while `joy_strobe`=0, the register shifts right and a 1 enters at the MSB. After 24 reads `joy_data` is constantly 1.
- `joy_data[i]` = bit 0 of shifter i, registered.
- Simultaneous strobe and falling clock edge: the load wins.

## Timing
- Reset values:
  - `split_sel`=0, `joy_data`=2'b11.
  - Pad slots, shifters, counters and synchronisers all cleared.
  - `last_clock`=0.
- Latency:
  - Pin to pad slot: 2 sync cycles plus up to 2×SPLIT_DIV.
  - Strobe to `joy_data`: 1 cycle.
  - Falling edge to next bit: 1 cycle.
- Reset mid-read: the shifter restarts from the reset value. The next strobe reloads it.
- Pad slots are never updated partway through a phase. Each slot holds the last full sample.

## Configuration
- `JOYPAD_TURBO_EN` defined:
  - Adds `turbo_en` and a TURBO_DIV counter that toggles `turbo_phase`.
  - For pads with `turbo_en`=1, A and B are ANDed with `turbo_phase` at shifter load.
  - `turbo_phase` resets to 1.
- Not defined: no port, no counter, A and B pass straight through.

## Structure
- Package `nes_joypad_pkg` holds:
  - button bit indices (BTN_A=0 … BTN_R=7);
  - `SIG_4016`=8'h08 and `SIG_4017`=8'h04;
  - the raw-pin index constants.
- Sub-module `nes_joypad_shifter` (24-bit load/shift, edge detect, data out) is instantiated twice.

## Test plan
- Single-pad load: NUM_PORTS=1, SPLIT=0, port_raw=6'b111110 (A pressed), strobe pulse, 8 falling edges on `joy_clock[0]` → `joy_data[0]` reads 1,0,0,0,0,0,0,0, then 1s.
- joySplitter: SPLIT=1, drive U low only while `split_sel`=1 → after 2×SPLIT_DIV, pad 1 on `$4017` reads bit 4 = 1 and pad 0 reads all zeros.
- Four Score: NUM_PORTS=2, SPLIT=1, all pads idle, 24 reads of `$4016` → bits 0–18 = 0, bit 19 = 1, bits 20–23 = 0; on `$4017`, bit 18 = 1.
- OSD and edge rules: `host_start`=1 → bit 3 = 1 on both channels. Strobe held high with clock pulses → `joy_data` stays at bit 0.
- Async reset mid-read: deassert `reset_n` after 3 reads → `joy_data`=11 immediately, `split_sel`=0. After release and a strobe, reads restart at bit 0.
- Turbo (macro on): TURBO_DIV=4, `turbo_en[0]`=1, A held → successive strobe/read-1 cycles spaced 4 cycles apart return alternating 1/0 for A.
